// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: owns F_PC, runs the instruction-memory req/ack handshake,
// buffers a word while D is stalled and holds a redirect that resolves mid-fetch.
module fetch_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] npc_in,
    input  logic        redirect,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ack,
    input  logic [31:0] im_rdata,
    output logic [31:0] F_PC,
    output logic [31:0] F_Instr,
    output logic        F_valid,
    output logic        dbg_state,
    output logic        dbg_pend_valid
);

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ibuf_q, ibuf_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic [31:0] next_pc;

    // A held redirect always beats npc_in, which by then points past the delay slot.
    assign next_pc = {(pend_valid_q ? pend_target_q[31:2] : npc_in[31:2]), 2'b00};

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ibuf_d        = ibuf_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        case (state_q)
            S_FETCH: begin
                if (im_ack) begin
                    if (!stall) begin
                        pc_d         = next_pc;
                        pend_valid_d = 1'b0;
                    end else begin
                        ibuf_d  = im_rdata;
                        state_d = S_READY;
                    end
                end else if (redirect && !stall && !pend_valid_q) begin
                    // Branch leaves D while its delay slot is still in flight.
                    pend_valid_d  = 1'b1;
                    pend_target_d = npc_in;
                end
            end
            S_READY: begin
                if (!stall) begin
                    pc_d         = next_pc;
                    pend_valid_d = 1'b0;
                    state_d      = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_PC;
            ibuf_q        <= 32'h0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ibuf_q        <= ibuf_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    // Reset gates the combinational outputs so an ack during reset is invisible.
    assign im_req         = !reset && (state_q == S_FETCH);
    assign im_addr        = pc_q;
    assign F_PC           = pc_q;
    assign F_valid        = !reset && ((state_q == S_READY) || im_ack);
    assign F_Instr        = reset ? 32'h0 :
                            ((state_q == S_FETCH) && im_ack) ? im_rdata : ibuf_q;
    assign dbg_state      = state_q;
    assign dbg_pend_valid = pend_valid_q;

endmodule
